// File: rtl/float_adder_pkg.sv
// float_adder_pkg: shared types and width helpers for the parametrised
// floating-point adder (state enum, derived widths, saturation constant).
package float_adder_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } state_t;

    // {sign, exp, man}
    function automatic int total_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // {hidden, man, guard, round, sticky}
    function automatic int ext_w(input int man_w);
        return man_w + 4;
    endfunction

    // Signed exponent with headroom for one overflow and underflow step.
    function automatic int iexp_w(input int exp_w);
        return exp_w + 2;
    endfunction

    // Largest finite magnitude {all-ones exp, all-ones man}, sign excluded.
    function automatic logic [31:0] sat_mag(input int exp_w, input int man_w);
        return (32'd1 << (exp_w + man_w)) - 32'd1;
    endfunction

endpackage

// File: rtl/float_adder_pipe_fsm_if.sv
// float_adder_pipe_fsm_if: operand and result channels of the adder.
//   in_valid/in_ready/a/b/sub      : operand channel (producer -> adder)
//   out_valid/out_ready/y/flags    : result channel (adder -> consumer)
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// The sender holds valid and payload stable until that transfer; ready may
// be asserted before valid and does not depend combinationally on valid.
interface float_adder_pipe_fsm_if #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
);
    import float_adder_pkg::*;

    localparam int TW = total_w(EXP_W, MAN_W);

    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] y;
    logic          overflow;
    logic          inexact;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, y, overflow, inexact
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, y, overflow, inexact
    );

endinterface

// File: rtl/fp_align_shift.sv
// fp_align_shift: combinational right shifter that keeps a sticky bit.
//   din  : value to shift (W >= 2)
//   sh   : shift amount; amounts >= W leave only the sticky bit
//   dout : din >> sh with every shifted-out 1 ORed into dout[0]
module fp_align_shift #(
    parameter int W    = 7,
    parameter int SH_W = 4
) (
    input  logic [W-1:0]    din,
    input  logic [SH_W-1:0] sh,
    output logic [W-1:0]    dout
);

    logic [W-1:0] shifted;
    logic [W-1:0] mask;
    logic         lost;

    always_comb begin
        shifted = din >> sh;
        mask    = ~({W{1'b1}} << sh);
        lost    = |(din & mask);
        dout    = {shifted[W-1:1], shifted[0] | lost};
    end

endmodule

// File: rtl/float_adder_pipe_fsm.sv
// float_adder_pipe_fsm: multi-cycle signed-magnitude FP adder/subtractor,
// one operation in flight, round-to-nearest-even, saturation, flush-to-zero.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : operand/result channels (slave side)
//   dbg_state    : current FSM state
module float_adder_pipe_fsm
    import float_adder_pkg::*;
#(
    parameter int EXP_W  = 4,
    parameter int MAN_W  = 3,
    parameter int SUB_EN = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    float_adder_pipe_fsm_if.slave   bus,
    output state_t                  dbg_state
);

    localparam int TW = total_w(EXP_W, MAN_W);
    localparam int EW = ext_w(MAN_W);
    localparam int IW = iexp_w(EXP_W);
    localparam logic signed [IW-1:0] EXP_MAX  = IW'((1 << EXP_W) - 1);
    localparam logic signed [IW-1:0] EXP_ONE  = IW'(1);
    localparam logic signed [IW-1:0] EXP_ZERO = '0;
    localparam logic [EXP_W+MAN_W-1:0] SAT    = (EXP_W+MAN_W)'(sat_mag(EXP_W, MAN_W));

    state_t                state;
    logic [TW-1:0]         op_a, op_b;
    logic                  sign_r, eff_sub;
    logic signed [IW-1:0]  exp_r;
    logic [EW-1:0]         man_l_r, man_s_r;
    logic [EW:0]           acc;
    logic [TW-1:0]         y_r;
    logic                  ovf_r, inx_r, out_valid_r, in_ready_r;

    // Capture: exp field 0 is zero, so subnormals become signed zero.
    logic          sub_eff;
    logic [TW-1:0] a_cap, b_cap;
    always_comb begin
        sub_eff = bus.sub & (SUB_EN != 0);
        a_cap   = (bus.a[TW-2 -: EXP_W] == '0) ? {bus.a[TW-1], {(TW-1){1'b0}}} : bus.a;
        b_cap   = (bus.b[TW-2 -: EXP_W] == '0) ? {bus.b[TW-1] ^ sub_eff, {(TW-1){1'b0}}}
                                               : {bus.b[TW-1] ^ sub_eff, bus.b[TW-2:0]};
    end

    // Align: the larger magnitude keeps its mantissa; the smaller is shifted.
    logic               a_big, sign_l, sign_s;
    logic [EXP_W-1:0]   exp_l, exp_s, d;
    logic [EW-1:0]      l_ext, s_ext, s_aligned;
    always_comb begin
        a_big  = op_a[TW-2:0] >= op_b[TW-2:0];
        sign_l = a_big ? op_a[TW-1] : op_b[TW-1];
        sign_s = a_big ? op_b[TW-1] : op_a[TW-1];
        exp_l  = a_big ? op_a[TW-2 -: EXP_W] : op_b[TW-2 -: EXP_W];
        exp_s  = a_big ? op_b[TW-2 -: EXP_W] : op_a[TW-2 -: EXP_W];
        // Hidden bit is 0 for a zero operand so zero aligns to nothing.
        l_ext  = a_big ? {(exp_l != '0), op_a[MAN_W-1:0], 3'b000}
                       : {(exp_l != '0), op_b[MAN_W-1:0], 3'b000};
        s_ext  = a_big ? {(exp_s != '0), op_b[MAN_W-1:0], 3'b000}
                       : {(exp_s != '0), op_a[MAN_W-1:0], 3'b000};
        d      = exp_l - exp_s;
    end

    fp_align_shift #(.W(EW), .SH_W(EXP_W)) u_align (
        .din  (s_ext),
        .sh   (d),
        .dout (s_aligned)
    );

    // Add: magnitude ordering guarantees L - S never goes negative.
    logic [EW:0] sum;
    always_comb begin
        sum = eff_sub ? ({1'b0, man_l_r} - {1'b0, man_s_r})
                      : ({1'b0, man_l_r} + {1'b0, man_s_r});
    end

    // Normalise step; right shift folds the dropped bit into sticky.
    logic [EW:0]          n_acc;
    logic signed [IW-1:0] n_exp;
    always_comb begin
        if (acc[EW]) begin
            n_acc = {1'b0, acc[EW:2], acc[1] | acc[0]};
            n_exp = exp_r + EXP_ONE;
        end else begin
            n_acc = {acc[EW-1:0], 1'b0};
            n_exp = exp_r - EXP_ONE;
        end
    end

    // Round to nearest even on {G, R, S} below the mantissa lsb.
    logic                 g_bit, r_bit, s_bit, inc;
    logic [MAN_W+1:0]     m_rnd;
    logic signed [IW-1:0] r_exp;
    logic [MAN_W-1:0]     r_man;
    always_comb begin
        g_bit = acc[2];
        r_bit = acc[1];
        s_bit = acc[0];
        inc   = g_bit & (r_bit | s_bit | acc[3]);
        m_rnd = {1'b0, acc[EW-1:3]} + (MAN_W+2)'(inc);
        r_exp = m_rnd[MAN_W+1] ? exp_r + EXP_ONE : exp_r;
        r_man = m_rnd[MAN_W+1] ? m_rnd[MAN_W:1] : m_rnd[MAN_W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            sign_r      <= 1'b0;
            eff_sub     <= 1'b0;
            exp_r       <= '0;
            man_l_r     <= '0;
            man_s_r     <= '0;
            acc         <= '0;
            y_r         <= '0;
            ovf_r       <= 1'b0;
            inx_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_a       <= a_cap;
                    op_b       <= b_cap;
                    y_r        <= '0;
                    ovf_r      <= 1'b0;
                    inx_r      <= 1'b0;
                    in_ready_r <= 1'b0;
                    state      <= ALIGN;
                end
                ALIGN: begin
                    sign_r  <= sign_l;
                    eff_sub <= sign_l ^ sign_s;
                    exp_r   <= {2'b00, exp_l};
                    man_l_r <= l_ext;
                    man_s_r <= s_aligned;
                    state   <= ADD;
                end
                ADD: begin
                    acc <= sum;
                    if (sum == '0) begin
                        y_r         <= '0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else if (!sum[EW] && sum[EW-1]) begin
                        state <= ROUND;
                    end else begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (n_exp <= EXP_ZERO) begin
                        y_r         <= '0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        acc   <= n_acc;
                        exp_r <= n_exp;
                        if (!n_acc[EW] && n_acc[EW-1]) state <= ROUND;
                    end
                end
                ROUND: begin
                    if (r_exp > EXP_MAX) begin
                        y_r   <= {sign_r, SAT};
                        ovf_r <= 1'b1;
                        inx_r <= 1'b1;
                    end else begin
                        y_r   <= {sign_r, r_exp[EXP_W-1:0], r_man};
                        inx_r <= g_bit | r_bit | s_bit;
                    end
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.y         = y_r;
    assign bus.overflow  = ovf_r;
    assign bus.inexact   = inx_r;
    assign dbg_state     = state;

endmodule

// File: tb/tb_float_adder_pipe_fsm.sv
module tb_float_adder_pipe_fsm;
    import float_adder_pkg::*;

    localparam int EXP_W = 4;
    localparam int MAN_W = 3;
    localparam int TW    = 1 + EXP_W + MAN_W;
    localparam int SW    = TW + 2;

    logic   clock = 1'b0;
    logic   reset = 1'b1;
    state_t dbg_state;

    float_adder_pipe_fsm_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    float_adder_pipe_fsm #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SUB_EN(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // scoreboard monitor: {overflow, inexact, y}
    always @(negedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got 0x%0h with empty queue", bus.y);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {22'd0, bus.overflow, bus.inexact, bus.y}, {22'd0, mon_exp});
            end
        end
    end

    // driver: one operation, latency and busy check, optional result stall
    task automatic do_op(input logic [TW-1:0] av, input logic [TW-1:0] bv, input logic sv,
                         input logic [TW-1:0] ey, input logic eo, input logic ei,
                         input int elat, input int hold);
        int   n;
        int   lat;
        logic saw_ready;
        @(posedge clock); #1;
        bus.out_ready = (hold == 0);
        bus.a         = av;
        bus.b         = bv;
        bus.sub       = sv;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        @(posedge clock);
        exp_q.push_back({eo, ei, ey});
        #1 bus.in_valid = 1'b0;
        lat       = 0;
        saw_ready = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) saw_ready = 1'b1;
            @(posedge clock); #1;
            lat++;
        end
        check("latency", lat, elat);
        check("in_ready_busy", saw_ready, 0);
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clock);
                check("hold_stable", {21'd0, bus.out_valid, bus.overflow, bus.inexact, bus.y},
                      {21'd0, 1'b1, eo, ei, ey});
            end
            @(posedge clock); #1;
            bus.out_ready = 1'b1;
        end
        n = 0;
        while (bus.out_valid && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        check("out_valid_drop", bus.out_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_y"},         bus.y, 0);
        check({tag, "_overflow"},  bus.overflow, 0);
        check({tag, "_inexact"},   bus.inexact, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_in_ready"},  bus.in_ready, 1);
        check({tag, "_state"},     dbg_state, IDLE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (2) @(posedge clock);
        #1 check_reset_outputs("in_reset");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check_reset_outputs("after_reset");

        //     a      b      sub   y      ovf   inx   lat hold
        do_op(8'h38, 8'h38, 1'b0, 8'h40, 1'b0, 1'b0, 4, 0);
        do_op(8'h38, 8'hB8, 1'b0, 8'h00, 1'b0, 1'b0, 2, 0);
        do_op(8'h39, 8'hB8, 1'b0, 8'h20, 1'b0, 1'b0, 6, 0);
        do_op(8'h38, 8'h18, 1'b0, 8'h38, 1'b0, 1'b1, 3, 0);
        do_op(8'h39, 8'h18, 1'b0, 8'h3A, 1'b0, 1'b1, 3, 0);
        do_op(8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b1, 1'b1, 4, 0);
        do_op(8'h05, 8'h38, 1'b0, 8'h38, 1'b0, 1'b0, 3, 0);
        do_op(8'h40, 8'h38, 1'b1, 8'h38, 1'b0, 1'b0, 4, 0);
        do_op(8'h38, 8'h40, 1'b1, 8'hB8, 1'b0, 1'b0, 4, 0);
        do_op(8'hB8, 8'hB8, 1'b0, 8'hC0, 1'b0, 1'b0, 4, 0);
        do_op(8'h39, 8'h18, 1'b0, 8'h3A, 1'b0, 1'b1, 3, 5);

        // abort an operation while it is normalising
        @(posedge clock); #1;
        bus.a        = 8'h39;
        bus.b        = 8'hB8;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (dbg_state != NORM && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check("reach_norm", dbg_state, NORM);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid_op_reset");
        @(negedge clock);
        reset = 1'b0;
        do_op(8'h38, 8'h38, 1'b0, 8'h40, 1'b0, 1'b0, 4, 0);

        repeat (3) @(posedge clock);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
